gameboy_joypad_ctrl: RTL and testbench
======================================

# gameboy_joypad_ctrl

Parametrised joypad controller for the Game Boy core: holds the 8-button state written by the host over Avalon-MM and drives the active-low P10–P13 return lines from the P14/P15 group selects. It adds select-line synchronisation, registered outputs, per-button turbo (autofire), readback and a joypad interrupt. It sits between the host-facing Avalon bus and the P1 register logic of the CPU core.

## Interface
- SYNC_STAGES, 2, synchroniser depth on P14/P15; legal ≥2.
- TURBO_DIV, 262144, clock cycles per turbo half-period; legal ≥2; counter width $clog2(TURBO_DIV).
- clk  in  1  single clock; every register updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- address_slv  in  2  register select.
- writedata_slv  in  8  write data.
- write_slv  in  1  write strobe, qualified by chipselect_slv.
- read_slv  in  1  read strobe, qualified by chipselect_slv.
- chipselect_slv  in  1  slave select.
- readdata_slv  out  8  registered read data.
- P15  in  1  action-group select, active-low (A/B/SELECT/START).
- P14  in  1  direction-group select, active-low (RIGHT/LEFT/UP/DOWN).
- P13, P12, P11, P10  out  1 each  button return lines, active-low, registered.
- joy_irq  out  1  level interrupt request, active-high.

## Operation
- Register map. Writes take effect when chipselect_slv && write_slv:
  - 0 BUTTONS, R/W. Bit set = pressed. Bits 0..7 = RIGHT, LEFT, UP, DOWN, A, B, SELECT, START.
  - 1 TURBO, R/W. Bit set = that button autofires.
  - 2 CTRL. Bit0 irq_enable, R/W. Bit1 irq_clear, write-1 to clear; self-clearing; reads 0. Bits 7:2 read 0.
  - 3 STATUS, RO. Bit0 irq_pending. Bits 4:1 = {P13,P12,P11,P10} current output values. Bits 7:5 = 0. Writes are ignored.
- Synchronisation: P14 and P15 each pass through SYNC_STAGES flops. The synchronised values are p14_s and p15_s.
- Turbo:
  - A free-running counter counts 0..TURBO_DIV-1, then wraps to 0.
  - turbo_phase toggles on each wrap.
  - Effective pressed vector: eff = BUTTONS & ~(TURBO & {8{~turbo_phase}}). A turbo button reads pressed only while turbo_phase=1.
- Output mapping, combinational next-state:
  - Start with nP1x = 1.
  - If p14_s=0: eff[0..3] force P10..P13 low, respectively.
  - If p15_s=0: eff[4..7] force P10..P13 low, respectively.
  - Both groups selected: lines are the AND of both groups. Neither selected: all lines 1.
  - P10..P13 register nP1x each cycle.
- Interrupt:
  - irq_pending sets on any registered P1x line going 1→0, detected by comparing with the previous registered value.
  - Setting does not depend on irq_enable.
  - A write of 1 to irq_clear clears irq_pending.
  - Falling edge and clear in the same cycle: set wins.
  - joy_irq = irq_pending && irq_enable, registered.
- Reads: when chipselect_slv && read_slv, readdata_slv loads the addressed register. Otherwise readdata_slv holds its value.

## Timing
- Reset values:
  - BUTTONS, TURBO, CTRL = 0; irq_pending = 0; turbo counter = 0; turbo_phase = 0.
  - Synchroniser flops = 1 (deselected).
  - P10..P13 = 1, joy_irq = 0, readdata_slv = 0.
- Reset asserted mid-operation returns everything to these values immediately. This is asynchronous and takes effect without a clock edge.
- P14/P15 change at the pins → P1x reflects it after SYNC_STAGES+1 rising edges.
- BUTTONS/TURBO write at edge N → P1x updated at edge N+1.
- P1x falls at edge N → irq_pending=1 at edge N+1 → joy_irq=1 at edge N+2 if enabled.
- Read latency: 1 cycle. readdata_slv is valid after the edge that samples the read strobe.
- A read of STATUS returns P1x as registered before that edge.
- Enabling irq while irq_pending=1 raises joy_irq one edge after the CTRL write.
- Turbo counter wraps at edge TURBO_DIV after reset. turbo_phase toggles on that same edge.

## Test plan
- Reset with P14=P15=1 → P10..P13=1, joy_irq=0, readdata_slv=0. Reading addr 0/1/2 returns 0x00. Reading STATUS returns 0x1E.
- BUTTONS=0x11, P14=0, P15=1 → after SYNC_STAGES+1 edges P10=0, P11..P13=1. Then P14=1, P15=0 → P10=0. Then both selects 1 → all 1.
- BUTTONS=0x81, both selects 0 → P10=0, P13=0, P11=P12=1. Read BUTTONS → 0x81.
- CTRL=0x01, P14=0, write BUTTONS=0x04 → P12 falls, irq_pending=1 next edge, joy_irq=1 the edge after. Write CTRL=0x03 → joy_irq=0 two edges later. Clear on the same edge as a new fall → pending stays 1.
- TURBO_DIV=4, TURBO=0x10, BUTTONS=0x10, P15=0 → P10 toggles with period 8 cycles. Each 1→0 transition sets irq_pending.
- Assert reset mid-turbo with BUTTONS≠0 → outputs return to 1 with no clock edge. After release, the turbo counter restarts from 0.

Source files
------------

// File: rtl/gameboy_joypad_ctrl.sv
// rtl/gameboy_joypad_ctrl.sv - Game Boy joypad controller with turbo, readback and interrupt
// Host writes the button/turbo registers; P14/P15 group selects pick which half drives P10..P13.
module gameboy_joypad_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int TURBO_DIV   = 262144
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] address_slv,
    input  logic [7:0] writedata_slv,
    input  logic       write_slv,
    input  logic       read_slv,
    input  logic       chipselect_slv,
    output logic [7:0] readdata_slv,
    input  logic       P15,
    input  logic       P14,
    output logic       P13,
    output logic       P12,
    output logic       P11,
    output logic       P10,
    output logic       joy_irq
);

    localparam int CW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam logic [CW-1:0] TURBO_LAST = CW'(TURBO_DIV - 1);

    logic [SYNC_STAGES-1:0] p14_sync_q, p15_sync_q;
    logic [7:0]             buttons_q, buttons_d;
    logic [7:0]             turbo_q, turbo_d;
    logic                   irq_en_q, irq_en_d;
    logic                   pending_q, pending_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   phase_q, phase_d;
    logic [3:0]             p1x_q, p1x_d;
    logic [3:0]             p1x_prev_q;
    logic                   joy_q, joy_d;
    logic [7:0]             rdata_q, rdata_d;

    logic       wr, rd, p14_s, p15_s, irq_clr, fall, wrap;
    logic [7:0] eff;

    assign wr    = chipselect_slv & write_slv;
    assign rd    = chipselect_slv & read_slv;
    assign p14_s = p14_sync_q[SYNC_STAGES-1];
    assign p15_s = p15_sync_q[SYNC_STAGES-1];
    assign wrap  = (cnt_q == TURBO_LAST);

    always_comb begin
        buttons_d = buttons_q;
        turbo_d   = turbo_q;
        irq_en_d  = irq_en_q;
        irq_clr   = 1'b0;
        if (wr) begin
            case (address_slv)
                2'd0: buttons_d = writedata_slv;
                2'd1: turbo_d   = writedata_slv;
                2'd2: begin
                    irq_en_d = writedata_slv[0];
                    irq_clr  = writedata_slv[1];
                end
                default: ;
            endcase
        end

        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        phase_d = phase_q ^ wrap;

        // Turbo buttons are masked off during the low half of the autofire period
        eff   = buttons_q & ~(turbo_q & {8{~phase_q}});
        p1x_d = 4'hF;
        if (!p14_s) p1x_d = p1x_d & ~eff[3:0];
        if (!p15_s) p1x_d = p1x_d & ~eff[7:4];

        fall = |(p1x_prev_q & ~p1x_q);
        if (fall)         pending_d = 1'b1;
        else if (irq_clr) pending_d = 1'b0;
        else              pending_d = pending_q;

        joy_d = pending_q & irq_en_q;

        rdata_d = rdata_q;
        if (rd) begin
            case (address_slv)
                2'd0:    rdata_d = buttons_q;
                2'd1:    rdata_d = turbo_q;
                2'd2:    rdata_d = {7'd0, irq_en_q};
                default: rdata_d = {3'd0, p1x_q, pending_q};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p14_sync_q <= '1;
            p15_sync_q <= '1;
            buttons_q  <= '0;
            turbo_q    <= '0;
            irq_en_q   <= 1'b0;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            p1x_q      <= 4'hF;
            p1x_prev_q <= 4'hF;
            joy_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            p14_sync_q <= {p14_sync_q[SYNC_STAGES-2:0], P14};
            p15_sync_q <= {p15_sync_q[SYNC_STAGES-2:0], P15};
            buttons_q  <= buttons_d;
            turbo_q    <= turbo_d;
            irq_en_q   <= irq_en_d;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            p1x_q      <= p1x_d;
            p1x_prev_q <= p1x_q;
            joy_q      <= joy_d;
            rdata_q    <= rdata_d;
        end
    end

    assign P10          = p1x_q[0];
    assign P11          = p1x_q[1];
    assign P12          = p1x_q[2];
    assign P13          = p1x_q[3];
    assign joy_irq      = joy_q;
    assign readdata_slv = rdata_q;

endmodule

// File: tb/tb_gameboy_joypad_ctrl.sv
// tb/tb_gameboy_joypad_ctrl.sv - directed self-checking bench for gameboy_joypad_ctrl
module tb_gameboy_joypad_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] address_slv;
    logic [7:0] writedata_slv;
    logic       write_slv, read_slv, chipselect_slv;
    logic [7:0] readdata_slv;
    logic       P15, P14, P13, P12, P11, P10, joy_irq;

    int checks = 0;
    int errors = 0;

    gameboy_joypad_ctrl #(.SYNC_STAGES(2), .TURBO_DIV(TD)) dut (
        .clk(clk), .reset(reset),
        .address_slv(address_slv), .writedata_slv(writedata_slv),
        .write_slv(write_slv), .read_slv(read_slv), .chipselect_slv(chipselect_slv),
        .readdata_slv(readdata_slv),
        .P15(P15), .P14(P14), .P13(P13), .P12(P12), .P11(P11), .P10(P10),
        .joy_irq(joy_irq)
    );

    always #5 clk = ~clk;

    wire [3:0] p1x = {P13, P12, P11, P10};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        address_slv = a; writedata_slv = d; chipselect_slv = 1'b1; write_slv = 1'b1;
        tick();
        chipselect_slv = 1'b0; write_slv = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        address_slv = a; chipselect_slv = 1'b1; read_slv = 1'b1;
        tick();
        chipselect_slv = 1'b0; read_slv = 1'b0;
        d = readdata_slv;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b0; P14 = 1'b1; P15 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (p1x !== 4'hF) begin errors++; $display("FAIL reset_p1x got=%h exp=f", p1x); end
        checks++; if (joy_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", joy_irq); end
        checks++; if (readdata_slv !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", readdata_slv); end
        reset = 1'b1;
        for (int a = 0; a < 3; a++) begin
            bus_read(2'(a), d);
            checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_read%0d got=%h exp=00", a, d); end
        end
        bus_read(2'd3, d);
        checks++; if (d !== 8'h1E) begin errors++; $display("FAIL reset_status got=%h exp=1e", d); end
    endtask

    task automatic test_select();
        bus_write(2'd0, 8'h11);
        P14 = 1'b0;
        repeat (2) tick();
        checks++; if (p1x !== 4'hF) begin errors++; $display("FAIL sel_latency got=%h exp=f", p1x); end
        tick();
        checks++; if (p1x !== 4'hE) begin errors++; $display("FAIL sel_dir got=%h exp=e", p1x); end
        P14 = 1'b1; P15 = 1'b0;
        repeat (3) tick();
        checks++; if (p1x !== 4'hE) begin errors++; $display("FAIL sel_act got=%h exp=e", p1x); end
        P15 = 1'b1;
        repeat (3) tick();
        checks++; if (p1x !== 4'hF) begin errors++; $display("FAIL sel_none got=%h exp=f", p1x); end
    endtask

    task automatic test_both_groups();
        logic [7:0] d;
        bus_write(2'd0, 8'h81);
        P14 = 1'b0; P15 = 1'b0;
        repeat (3) tick();
        checks++; if (p1x !== 4'h6) begin errors++; $display("FAIL both_p1x got=%h exp=6", p1x); end
        bus_read(2'd0, d);
        checks++; if (d !== 8'h81) begin errors++; $display("FAIL both_read got=%h exp=81", d); end
        P14 = 1'b1; P15 = 1'b1;
        repeat (3) tick();
        checks++; if (p1x !== 4'hF) begin errors++; $display("FAIL both_release got=%h exp=f", p1x); end
    endtask

    task automatic test_irq();
        logic [7:0] d;
        bus_write(2'd0, 8'h00);
        P14 = 1'b0;
        repeat (3) tick();
        bus_write(2'd2, 8'h02);
        bus_write(2'd2, 8'h01);
        tick();
        checks++; if (joy_irq !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b exp=0", joy_irq); end
        bus_write(2'd0, 8'h04);
        tick();
        checks++; if (p1x !== 4'hB) begin errors++; $display("FAIL irq_p12_fall got=%h exp=b", p1x); end
        tick();
        checks++; if (joy_irq !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", joy_irq); end
        tick();
        checks++; if (joy_irq !== 1'b1) begin errors++; $display("FAIL irq_raise got=%b exp=1", joy_irq); end
        bus_read(2'd3, d);
        checks++; if (d !== 8'h17) begin errors++; $display("FAIL irq_status got=%h exp=17", d); end
        bus_write(2'd2, 8'h03);
        checks++; if (joy_irq !== 1'b1) begin errors++; $display("FAIL irq_clr_hold got=%b exp=1", joy_irq); end
        tick();
        checks++; if (joy_irq !== 1'b0) begin errors++; $display("FAIL irq_clr got=%b exp=0", joy_irq); end
        // pending while disabled, then enable
        bus_write(2'd2, 8'h00);
        bus_write(2'd0, 8'h00);
        tick();
        bus_write(2'd0, 8'h04);
        repeat (3) tick();
        checks++; if (joy_irq !== 1'b0) begin errors++; $display("FAIL irq_masked got=%b exp=0", joy_irq); end
        bus_write(2'd2, 8'h01);
        checks++; if (joy_irq !== 1'b0) begin errors++; $display("FAIL irq_en_early got=%b exp=0", joy_irq); end
        tick();
        checks++; if (joy_irq !== 1'b1) begin errors++; $display("FAIL irq_en_late got=%b exp=1", joy_irq); end
        // clear colliding with a new fall
        bus_write(2'd2, 8'h03);
        repeat (2) tick();
        checks++; if (joy_irq !== 1'b0) begin errors++; $display("FAIL irq_pre_collide got=%b exp=0", joy_irq); end
        bus_write(2'd0, 8'h00);
        repeat (2) tick();
        bus_write(2'd0, 8'h04);
        tick();
        bus_write(2'd2, 8'h03);
        tick();
        checks++; if (joy_irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins got=%b exp=1", joy_irq); end
        bus_read(2'd3, d);
        checks++; if (d !== 8'h17) begin errors++; $display("FAIL irq_set_wins_status got=%h exp=17", d); end
    endtask

    // Edge k counts from reset release; writes TURBO, BUTTONS, CTRL on edges 1..3, clears on edge 10
    task automatic turbo_run(input int last_edge);
        logic [3:0] exp_p1x;
        logic       exp_joy;
        for (int k = 1; k <= last_edge; k++) begin
            chipselect_slv = 1'b0; write_slv = 1'b0;
            case (k)
                1:  begin address_slv = 2'd1; writedata_slv = 8'h10; chipselect_slv = 1'b1; write_slv = 1'b1; end
                2:  begin address_slv = 2'd0; writedata_slv = 8'h10; chipselect_slv = 1'b1; write_slv = 1'b1; end
                3:  begin address_slv = 2'd2; writedata_slv = 8'h01; chipselect_slv = 1'b1; write_slv = 1'b1; end
                10: begin address_slv = 2'd2; writedata_slv = 8'h03; chipselect_slv = 1'b1; write_slv = 1'b1; end
                default: ;
            endcase
            tick();
            chipselect_slv = 1'b0; write_slv = 1'b0;
            if (k >= 3) begin
                exp_p1x = {3'b111, ~(((k - 1) / TD) % 2 == 1)};
                exp_joy = ((k >= 7) && (k <= 10)) || (k >= 15);
                checks++; if (p1x !== exp_p1x) begin errors++; $display("FAIL turbo_p1x edge%0d got=%h exp=%h", k, p1x, exp_p1x); end
                checks++; if (joy_irq !== exp_joy) begin errors++; $display("FAIL turbo_irq edge%0d got=%b exp=%b", k, joy_irq, exp_joy); end
            end
        end
    endtask

    task automatic test_turbo_reset();
        logic [7:0] d;
        reset = 1'b0; P14 = 1'b1; P15 = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        turbo_run(22);
        bus_read(2'd0, d);
        checks++; if (d !== 8'h10) begin errors++; $display("FAIL turbo_read got=%h exp=10", d); end
        checks++; if (p1x !== 4'hE) begin errors++; $display("FAIL turbo_pre_rst got=%h exp=e", p1x); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (p1x !== 4'hF) begin errors++; $display("FAIL async_rst_p1x got=%h exp=f", p1x); end
        checks++; if (joy_irq !== 1'b0) begin errors++; $display("FAIL async_rst_irq got=%b exp=0", joy_irq); end
        checks++; if (readdata_slv !== 8'h00) begin errors++; $display("FAIL async_rst_rdata got=%h exp=00", readdata_slv); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        turbo_run(12);
    endtask

    initial begin
        reset = 1'b0; address_slv = '0; writedata_slv = '0;
        write_slv = 1'b0; read_slv = 1'b0; chipselect_slv = 1'b0;
        P14 = 1'b1; P15 = 1'b1;
        test_reset();
        test_select();
        test_both_groups();
        test_irq();
        test_turbo_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
